pipe_ctrl_gen: RTL and testbench
================================

// Module: pipe_ctrl_gen
// PURPOSE
//  Parametrised pipeline stall/flush controller, successor of the fixed 6-stage ctrl.
//  Sits beside the pipeline registers; turns per-stage stall requests and the final
//  exception type into the stall vector, a registered multi-cycle flush, and the redirect PC.
//  Adds selectable vectoring, a stall performance counter and a stall watchdog.
// PARAMETERS
//  NUM_STAGES  6             number of stall bits; bit 0 = PC, bit NUM_STAGES-1 = last stage
//  EXC_W       32            width of exc_type
//  FLUSH_CYC   1             cycles flush is held per exception (>=1)
//  VEC_MODE    0             0: ebase/epc vectoring; 1: fixed MIPS vectors (BEV/EXL/IV)
//  RESET_VEC   32'hBFC00000  new_pc value out of reset
//  ERET_CODE, INT_CODE, TLBL_CODE, TLBS_CODE  exc_type encodings (match defines.v)
//  CNT_W       32            width of stall_cnt
//  MAX_STALL   1024          consecutive-stall cycles before stall_timeout
// PORTS
//  clk            in   1           clock, all state on rising edge
//  rst            in   1           synchronous reset, active-high
//  stallreq       in   NUM_STAGES  stallreq[k]=1: stage k requests stall
//  exc_type       in   EXC_W       final exception type, 0 = none
//  cp0_epc        in   32          EPC for ERET
//  ebase          in   32          exception base (VEC_MODE 0)
//  status         in   32          CP0 Status (BEV=bit22, EXL=bit1)
//  cause          in   32          CP0 Cause (IV=bit23)
//  stall          out  NUM_STAGES  stall vector, bit k freezes stage k
//  flush          out  1           pipeline flush, registered
//  new_pc         out  32          redirect target, valid while flush=1
//  busy           out  1           1 while FSM not IDLE
//  stall_cnt      out  CNT_W       cycles with stall!=0, saturating
//  stall_timeout  out  1           sticky: MAX_STALL consecutive stall cycles seen
// BEHAVIOUR
//  Reset: stall=0, flush=0, new_pc=RESET_VEC, busy=0, stall_cnt=0, stall_timeout=0, FSM=IDLE.
//  Stall (combinational, IDLE only): k = highest set bit of stallreq; stall[k:0]=1, others 0.
//   Exception: stallreq[0] alone (PC request) => stall = all ones.
//   exc_type!=0 in IDLE forces stall=0 that same cycle. stall=0 in FLUSH and RECOVER.
//  FSM IDLE -> FLUSH -> RECOVER -> IDLE.
//   IDLE: exc_type!=0 at edge t => FLUSH; new_pc computed and registered, flush=1 from t+1.
//   FLUSH: flush=1, new_pc held, busy=1; internal count runs FLUSH_CYC cycles, then RECOVER.
//    exc_type sampled in FLUSH/RECOVER is ignored (pipeline being cleared).
//   RECOVER: flush=0, busy=1, stall=0, new_pc held, 1 cycle, then IDLE.
//  Vector (sampled with exc_type):
//   ERET_CODE -> cp0_epc in both modes.
//   VEC_MODE 0: any other nonzero code -> ebase.
//   VEC_MODE 1: TLBL/TLBS: BEV0 EXL0 80000000, BEV0 EXL1 80000180,
//    BEV1 EXL0 BFC00200, BEV1 EXL1 BFC00380;
//    INT: BEV0 IV0 80000180, BEV0 IV1 80000200, BEV1 IV0 BFC00380, BEV1 IV1 BFC00400;
//    other: BEV0 80000180, BEV1 BFC00380.
//  stall_cnt: +1 each cycle stall!=0, holds at all ones (no wrap).
//  Watchdog: run counter +1 per cycle stall!=0, cleared when stall==0;
//   stall_timeout set when run reaches MAX_STALL, stays 1 until rst.
//  rst mid-FLUSH: all state/outputs to reset values next edge; the exception is lost.
// TESTING
//  NUM_STAGES=6, stallreq=6'b001000 -> stall=6'b001111; 6'b000001 -> 111111; 6'b010100 -> 011111.
//  VEC_MODE0 FLUSH_CYC=2, exc_type=INT_CODE, ebase=80001000 at edge t ->
//   flush=1 cycles t+1,t+2; new_pc=80001000; busy=1 to t+3; IDLE at t+4.
//  VEC_MODE1 status[22]=1 cause[23]=1 INT -> new_pc=BFC00400;
//   status[22]=0 status[1]=1 TLBS -> 80000180; ERET, epc=1234 -> 00001234.
//  Exception with stallreq=6'b000100 in same cycle -> stall=0 that cycle, flush next;
//   second exception during FLUSH -> ignored, new_pc unchanged.
//  MAX_STALL=4, hold stallreq[3] 4 cycles -> stall_timeout=1 and sticky after release;
//   stall_cnt=4; CNT_W=3, 10 stall cycles -> stall_cnt=7.
//  Assert rst during FLUSH -> next cycle flush=0, new_pc=BFC00000, busy=0, counters 0.

Source files
------------

// File: rtl/pipe_ctrl_gen.sv
// Pipeline stall/flush controller: turns per-stage stall requests and the final
// exception type into a stall vector, a registered multi-cycle flush and a redirect PC.
module pipe_ctrl_gen #(
    parameter int               NUM_STAGES = 6,
    parameter int               EXC_W      = 32,
    parameter int               FLUSH_CYC  = 1,
    parameter int               VEC_MODE   = 0,
    parameter logic [31:0]      RESET_VEC  = 32'hBFC0_0000,
    parameter logic [EXC_W-1:0] ERET_CODE  = EXC_W'('hE),
    parameter logic [EXC_W-1:0] INT_CODE   = EXC_W'('h1),
    parameter logic [EXC_W-1:0] TLBL_CODE  = EXC_W'('h2),
    parameter logic [EXC_W-1:0] TLBS_CODE  = EXC_W'('h3),
    parameter int               CNT_W      = 32,
    parameter int               MAX_STALL  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stallreq,
    input  logic [EXC_W-1:0]      exc_type,
    input  logic [31:0]           cp0_epc,
    input  logic [31:0]           ebase,
    input  logic [31:0]           status,
    input  logic [31:0]           cause,
    output logic [NUM_STAGES-1:0] stall,
    output logic                  flush,
    output logic [31:0]           new_pc,
    output logic                  busy,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic                  stall_timeout
);

    localparam int FC_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int RUN_W = $clog2(MAX_STALL + 1);
    localparam logic [FC_W-1:0]       FC_LAST  = FC_W'(FLUSH_CYC - 1);
    localparam logic [RUN_W-1:0]      RUN_MAX  = RUN_W'(MAX_STALL);
    localparam logic [RUN_W-1:0]      RUN_LAST = RUN_W'(MAX_STALL - 1);
    localparam logic [NUM_STAGES-1:0] PC_ONLY  = NUM_STAGES'(1);

    typedef enum logic [1:0] {IDLE, FLUSH, RECOVER} state_t;

    state_t            state_reg, state_next;
    logic [FC_W-1:0]   fcnt_reg, fcnt_next;
    logic              flush_reg;
    logic [31:0]       new_pc_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic [RUN_W-1:0]  run_reg;
    logic              timeout_reg;
    logic              load_pc;
    logic              exc_valid;
    logic [31:0]       vec_pc;
    logic [NUM_STAGES-1:0] stall_mask;
    logic [NUM_STAGES-1:0] stall_next;
    logic              unused_bits;

    assign exc_valid   = (exc_type != '0);
    assign unused_bits = ^{status[31:23], status[21:2], status[0], cause[31:24], cause[22:0]};

    // Stage gi stalls when any stage at or after it requests a stall.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_mask
            assign stall_mask[gi] = |stallreq[NUM_STAGES-1:gi];
        end
    endgenerate

    always_comb begin
        stall_next = '0;
        if (state_reg == IDLE && !exc_valid) begin
            if (stallreq == PC_ONLY)
                stall_next = '1;
            else
                stall_next = stall_mask;
        end
    end

    // Fixed vectors: TLB refill/other/INT all offset from a BEV-selected base.
    always_comb begin
        logic [31:0] base;
        base   = status[22] ? 32'hBFC0_0200 : 32'h8000_0000;
        vec_pc = ebase;
        if (exc_type == ERET_CODE) begin
            vec_pc = cp0_epc;
        end else if (VEC_MODE == 1) begin
            if (exc_type == TLBL_CODE || exc_type == TLBS_CODE)
                vec_pc = base + (status[1] ? 32'h180 : 32'h0);
            else if (exc_type == INT_CODE)
                vec_pc = base + (cause[23] ? 32'h200 : 32'h180);
            else
                vec_pc = base + 32'h180;
        end
    end

    always_comb begin
        state_next = state_reg;
        fcnt_next  = fcnt_reg;
        load_pc    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (exc_valid) begin
                    state_next = FLUSH;
                    fcnt_next  = '0;
                    load_pc    = 1'b1;
                end
            end
            FLUSH: begin
                if (fcnt_reg == FC_LAST)
                    state_next = RECOVER;
                else
                    fcnt_next = fcnt_reg + 1'b1;
            end
            RECOVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            fcnt_reg      <= '0;
            flush_reg     <= 1'b0;
            new_pc_reg    <= RESET_VEC;
            stall_cnt_reg <= '0;
            run_reg       <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            fcnt_reg  <= fcnt_next;
            flush_reg <= (state_next == FLUSH);
            if (load_pc)
                new_pc_reg <= vec_pc;
            if (stall_next != '0 && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            // Run length saturates at the limit; the timeout flag is sticky.
            if (stall_next != '0) begin
                if (run_reg != RUN_MAX)
                    run_reg <= run_reg + 1'b1;
                if (run_reg == RUN_LAST)
                    timeout_reg <= 1'b1;
            end else begin
                run_reg <= '0;
            end
        end
    end

    assign stall         = stall_next;
    assign flush         = flush_reg;
    assign new_pc        = new_pc_reg;
    assign busy          = (state_reg != IDLE);
    assign stall_cnt     = stall_cnt_reg;
    assign stall_timeout = timeout_reg;

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Directed bench: one ebase-vectored instance (FLUSH_CYC=2, MAX_STALL=4) and one
// fixed-vector instance (FLUSH_CYC=1, CNT_W=3) driven from shared inputs.
module tb_pipe_ctrl_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stallreq;
    logic [31:0] exc_type, cp0_epc, ebase, status, cause;

    logic [5:0]  a_stall, b_stall;
    logic        a_flush, b_flush, a_busy, b_busy, a_to, b_to;
    logic [31:0] a_pc, b_pc, a_cnt;
    logic [2:0]  b_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_ctrl_gen #(.NUM_STAGES(6), .FLUSH_CYC(2), .VEC_MODE(0), .MAX_STALL(4), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .stallreq(stallreq), .exc_type(exc_type), .cp0_epc(cp0_epc),
        .ebase(ebase), .status(status), .cause(cause), .stall(a_stall), .flush(a_flush),
        .new_pc(a_pc), .busy(a_busy), .stall_cnt(a_cnt), .stall_timeout(a_to));

    pipe_ctrl_gen #(.NUM_STAGES(6), .FLUSH_CYC(1), .VEC_MODE(1), .MAX_STALL(1024), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .stallreq(stallreq), .exc_type(exc_type), .cp0_epc(cp0_epc),
        .ebase(ebase), .status(status), .cause(cause), .stall(b_stall), .flush(b_flush),
        .new_pc(b_pc), .busy(b_busy), .stall_cnt(b_cnt), .stall_timeout(b_to));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Vector table for the fixed-vector instance: code, status, cause, expected PC.
    logic [31:0] tv_code [0:8] = '{32'h1, 32'h3, 32'hE, 32'h2, 32'h2, 32'h1, 32'h8, 32'h8, 32'h3};
    logic [31:0] tv_stat [0:8] = '{32'h0040_0000, 32'h2, 32'h0, 32'h0040_0000, 32'h0040_0002,
                                   32'h0, 32'h0040_0000, 32'h0, 32'h0};
    logic [31:0] tv_caus [0:8] = '{32'h0080_0000, 32'h0, 32'h0, 32'h0, 32'h0,
                                   32'h0080_0000, 32'h0, 32'h0, 32'h0};
    logic [31:0] tv_exp  [0:8] = '{32'hBFC0_0400, 32'h8000_0180, 32'h0000_1234, 32'hBFC0_0200,
                                   32'hBFC0_0380, 32'h8000_0200, 32'hBFC0_0380, 32'h8000_0180,
                                   32'h8000_0000};

    initial begin
        rst = 1'b1; stallreq = '0; exc_type = '0; cp0_epc = 32'h1234;
        ebase = '0; status = '0; cause = '0;
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("rst_a_stall", {26'd0, a_stall}, 32'h0);
        chk("rst_a_flush", {31'd0, a_flush}, 32'h0);
        chk("rst_a_pc", a_pc, 32'hBFC0_0000);
        chk("rst_a_busy", {31'd0, a_busy}, 32'h0);
        chk("rst_a_cnt", a_cnt, 32'h0);
        chk("rst_a_to", {31'd0, a_to}, 32'h0);
        chk("rst_b_pc", b_pc, 32'hBFC0_0000);

        // Combinational stall patterns, no clock edge in between
        stallreq = 6'b001000; #1; chk("stall_001000", {26'd0, a_stall}, 32'h0F);
        stallreq = 6'b000001; #1; chk("stall_pc_only", {26'd0, a_stall}, 32'h3F);
        stallreq = 6'b010100; #1; chk("stall_010100", {26'd0, a_stall}, 32'h1F);
        stallreq = 6'b100000; #1; chk("stall_top", {26'd0, a_stall}, 32'h3F);
        stallreq = 6'b000011; #1; chk("stall_000011", {26'd0, a_stall}, 32'h03);
        stallreq = 6'b000000; #1; chk("stall_none", {26'd0, b_stall}, 32'h00);

        // Exception with simultaneous stall request
        stallreq = 6'b000100; exc_type = 32'h1; ebase = 32'h8000_1000; #1;
        chk("exc_a_stall0", {26'd0, a_stall}, 32'h0);
        chk("exc_b_stall0", {26'd0, b_stall}, 32'h0);
        step();
        exc_type = 32'hE; ebase = 32'hDEAD_0000; #1;
        chk("t1_a_flush", {31'd0, a_flush}, 32'h1);
        chk("t1_a_pc", a_pc, 32'h8000_1000);
        chk("t1_a_busy", {31'd0, a_busy}, 32'h1);
        chk("t1_a_stall", {26'd0, a_stall}, 32'h0);
        chk("t1_b_flush", {31'd0, b_flush}, 32'h1);
        chk("t1_b_pc", b_pc, 32'h8000_0180);
        step();
        exc_type = '0; stallreq = '0;
        chk("t2_a_flush", {31'd0, a_flush}, 32'h1);
        chk("t2_a_pc_kept", a_pc, 32'h8000_1000);
        chk("t2_b_flush", {31'd0, b_flush}, 32'h0);
        chk("t2_b_busy", {31'd0, b_busy}, 32'h1);
        chk("t2_b_pc_kept", b_pc, 32'h8000_0180);
        step();
        stallreq = 6'b001000; #1;
        chk("t3_a_flush", {31'd0, a_flush}, 32'h0);
        chk("t3_a_busy", {31'd0, a_busy}, 32'h1);
        chk("t3_a_stall", {26'd0, a_stall}, 32'h0);
        chk("t3_b_busy", {31'd0, b_busy}, 32'h0);
        chk("t3_b_stall", {26'd0, b_stall}, 32'h0F);
        stallreq = '0;
        step();
        chk("t4_a_busy", {31'd0, a_busy}, 32'h0);
        chk("t4_a_pc", a_pc, 32'h8000_1000);

        // Watchdog and saturating counter
        stallreq = 6'b001000;
        repeat (3) step();
        chk("wd3_a_to", {31'd0, a_to}, 32'h0);
        chk("wd3_a_cnt", a_cnt, 32'd3);
        step();
        chk("wd4_a_to", {31'd0, a_to}, 32'h1);
        chk("wd4_a_cnt", a_cnt, 32'd4);
        chk("wd4_b_cnt", {29'd0, b_cnt}, 32'd4);
        stallreq = '0;
        step();
        chk("wd_sticky", {31'd0, a_to}, 32'h1);
        chk("wd_a_cnt_hold", a_cnt, 32'd4);
        stallreq = 6'b000001;
        repeat (6) step();
        stallreq = '0;
        chk("sat_b_cnt", {29'd0, b_cnt}, 32'd7);
        chk("sat_a_cnt", a_cnt, 32'd10);
        chk("b_no_to", {31'd0, b_to}, 32'h0);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            exc_type = tv_code[i]; status = tv_stat[i]; cause = tv_caus[i];
            ebase = 32'h9000_0000 | (i << 4);
            step();
            exc_type = '0;
            chk($sformatf("vec%0d_b_pc", i), b_pc, tv_exp[i]);
            chk($sformatf("vec%0d_a_pc", i), a_pc,
                (tv_code[i] == 32'hE) ? 32'h1234 : (32'h9000_0000 | (i << 4)));
            repeat (3) step();
        end
        status = '0; cause = '0;

        // Reset in the middle of a flush
        exc_type = 32'h1; ebase = 32'h8000_5000;
        step();
        exc_type = '0;
        chk("rf_a_flush", {31'd0, a_flush}, 32'h1);
        chk("rf_a_pc", a_pc, 32'h8000_5000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rf_a_flush0", {31'd0, a_flush}, 32'h0);
        chk("rf_a_pc_rst", a_pc, 32'hBFC0_0000);
        chk("rf_a_busy0", {31'd0, a_busy}, 32'h0);
        chk("rf_a_cnt0", a_cnt, 32'h0);
        chk("rf_a_to0", {31'd0, a_to}, 32'h0);
        chk("rf_b_cnt0", {29'd0, b_cnt}, 32'h0);
        step();
        chk("rf_lost_flush", {31'd0, a_flush}, 32'h0);
        chk("rf_lost_busy", {31'd0, a_busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
